// File: rtl/press_count_pkg.sv
// press_count_pkg: shared constants and the count-action type for the
// press_count block.
package press_count_pkg;

  // Default counter width and its all-ones ceiling.
  localparam int COUNT_W_DEF = 8;
  localparam logic [COUNT_W_DEF-1:0] COUNT_MAX = '1;

  // What the counter does on a given edge.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_UP   = 2'd1,
    ACT_DOWN = 2'd2
  } count_act_e;

endpackage

// File: rtl/press_edge.sv
// press_edge: turns one button level into a single-cycle rise pulse.
// With PRESS_COUNT_SYNC_EN defined the level first passes a two-flop
// synchronizer; otherwise it feeds the edge detector directly.
module press_edge
  import press_count_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_s;
  logic btn_vld;
  logic prev_p0;

`ifdef PRESS_COUNT_SYNC_EN
  logic sync_p0;
  logic sync_p1;
  logic vld_p0;
  logic vld_p1;

  // Two-flop synchronizer; vld marks when the pipe holds real samples so
  // the reset-cleared flops cannot masquerade as a released button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

  assign btn_s   = sync_p1;
  assign btn_vld = vld_p1;
`else
  assign btn_s   = btn;
  assign btn_vld = 1'b1;
`endif

  // Previous-sample register; reset to 1 so a level already high at
  // reset release needs a fresh 0->1 before it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_p0 <= 1'b1;
    end else if (btn_vld) begin
      prev_p0 <= btn_s;
    end
  end

  assign rise = btn_vld & btn_s & ~prev_p0;

endmodule

// File: rtl/press_count.sv
// press_count: saturating up/down press counter driven by two buttons.
// Optional build macro: PRESS_COUNT_SYNC_EN (adds input synchronizers
// inside press_edge; counting rules are unchanged).
module press_count
  import press_count_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clock0,
  input  logic               clock180,
  input  logic               reset,
  input  logic               countu,
  input  logic               countd,
  output logic [COUNT_W-1:0] nr_presses
);

  localparam logic [COUNT_W-1:0] CNT_TOP = {COUNT_W{1'b1}};

  // clock180 exists only for interface compatibility.
  logic unused_clock180;
  assign unused_clock180 = clock180;

  logic       rise_u;
  logic       rise_d;
  count_act_e act;
  logic [COUNT_W-1:0] count_p0;

  // One step of the counter, clamped at both ends.
  function automatic logic [COUNT_W-1:0] sat_next(
    input logic [COUNT_W-1:0] cur,
    input count_act_e         a
  );
    logic [COUNT_W-1:0] nxt;
    nxt = cur;
    case (a)
      ACT_UP:   if (cur != CNT_TOP) nxt = cur + COUNT_W'(1);
      ACT_DOWN: if (cur != '0)      nxt = cur - COUNT_W'(1);
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

  press_edge u_edge_u (
    .clk  (clock0),
    .rst  (reset),
    .btn  (countu),
    .rise (rise_u)
  );

  press_edge u_edge_d (
    .clk  (clock0),
    .rst  (reset),
    .btn  (countd),
    .rise (rise_d)
  );

  // Decode the two rise pulses; simultaneous presses cancel.
  always_comb begin
    act = ACT_HOLD;
    if (rise_u && !rise_d) act = ACT_UP;
    else if (rise_d && !rise_u) act = ACT_DOWN;
  end

  // Counter register; reset wins over any press on the same edge.
  always_ff @(posedge clock0) begin
    if (reset) begin
      count_p0 <= '0;
    end else begin
      count_p0 <= sat_next(count_p0, act);
    end
  end

  assign nr_presses = count_p0;

endmodule

// File: tb/tb_press_count.sv
// tb_press_count: directed scenarios plus a randomized run checked against
// a behavioural press-counting model (default build).
`timescale 1ns/100ps
module tb_press_count;

  logic       clock0;
  logic       clock180;
  logic       reset;
  logic       countu;
  logic       countd;
  logic [7:0] nr_presses;

  int ntests;
  int nfail;

  // Reference model state: last sampled button levels and the count.
  int m_cnt;
  bit m_prev_u;
  bit m_prev_d;

  press_count #(.COUNT_W(8)) dut (
    .clock0     (clock0),
    .clock180   (clock180),
    .reset      (reset),
    .countu     (countu),
    .countd     (countd),
    .nr_presses (nr_presses)
  );

  initial clock0 = 1'b0;
  always #2 clock0 = ~clock0;
  assign clock180 = ~clock0;

  // Apply levels for one rising edge, advance the model, settle 1 ns.
  task automatic tick(input bit u, input bit d, input bit r);
    bit up;
    bit dn;
    @(negedge clock0);
    countu = u;
    countd = d;
    reset  = r;
    @(posedge clock0);
    if (r) begin
      m_cnt    = 0;
      m_prev_u = 1'b1;
      m_prev_d = 1'b1;
    end else begin
      up = u && !m_prev_u;
      dn = d && !m_prev_d;
      if (up && !dn) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      else if (dn && !up) m_cnt = (m_cnt <= 0) ? 0 : m_cnt - 1;
      m_prev_u = u;
      m_prev_d = d;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(0, 0, 1);
    tick(0, 0, 1);
    ntests++;
    if (nr_presses !== 8'd0) begin
      nfail++;
      $display("FAIL reset_value: got %0d expected 0", nr_presses);
    end
    repeat (3) tick(0, 0, 0);
    ntests++;
    if (nr_presses !== 8'd0) begin
      nfail++;
      $display("FAIL idle_after_reset: got %0d expected 0", nr_presses);
    end
  endtask

  task automatic test_pulses();
    tick(1, 0, 0);
    ntests++;
    if (nr_presses !== 8'd1) begin
      nfail++;
      $display("FAIL first_pulse: got %0d expected 1", nr_presses);
    end
    repeat (11) tick(0, 0, 0);
    ntests++;
    if (nr_presses !== 8'd1) begin
      nfail++;
      $display("FAIL between_pulses: got %0d expected 1", nr_presses);
    end
    tick(1, 0, 0);
    ntests++;
    if (nr_presses !== 8'd2) begin
      nfail++;
      $display("FAIL second_pulse: got %0d expected 2", nr_presses);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_hold_down();
    for (int i = 0; i < 58; i++) begin
      tick(0, 1, 0);
      ntests++;
      if (nr_presses !== 8'd1) begin
        nfail++;
        $display("FAIL hold_down cycle %0d: got %0d expected 1", i, nr_presses);
      end
    end
    tick(0, 0, 0);
  endtask

  task automatic test_hold_up();
    repeat (25) tick(1, 0, 0);
    ntests++;
    if (nr_presses !== 8'd2) begin
      nfail++;
      $display("FAIL hold_up_first: got %0d expected 2", nr_presses);
    end
    tick(0, 0, 0);
    repeat (25) tick(1, 0, 0);
    ntests++;
    if (nr_presses !== 8'd3) begin
      nfail++;
      $display("FAIL hold_up_second: got %0d expected 3", nr_presses);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_saturation();
    tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 1, 0);
    ntests++;
    if (nr_presses !== 8'd0) begin
      nfail++;
      $display("FAIL floor: got %0d expected 0", nr_presses);
    end
    tick(0, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
      if (i == 255) begin
        ntests++;
        if (nr_presses !== 8'd255) begin
          nfail++;
          $display("FAIL reach_top: got %0d expected 255", nr_presses);
        end
      end
    end
    ntests++;
    if (nr_presses !== 8'd255) begin
      nfail++;
      $display("FAIL ceiling: got %0d expected 255", nr_presses);
    end
    tick(0, 1, 0);
    ntests++;
    if (nr_presses !== 8'd254) begin
      nfail++;
      $display("FAIL down_from_top: got %0d expected 254", nr_presses);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_simultaneous();
    tick(1, 1, 0);
    ntests++;
    if (nr_presses !== 8'd254) begin
      nfail++;
      $display("FAIL both_rise: got %0d expected 254", nr_presses);
    end
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(1, 1, 0);
    ntests++;
    if (nr_presses !== 8'd254) begin
      nfail++;
      $display("FAIL up_then_down_held: got %0d expected 254", nr_presses);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_reset_mid_hold();
    tick(1, 0, 0);
    tick(1, 0, 1);
    ntests++;
    if (nr_presses !== 8'd0) begin
      nfail++;
      $display("FAIL reset_mid_hold: got %0d expected 0", nr_presses);
    end
    repeat (5) tick(1, 0, 0);
    ntests++;
    if (nr_presses !== 8'd0) begin
      nfail++;
      $display("FAIL held_after_reset: got %0d expected 0", nr_presses);
    end
    tick(0, 0, 0);
    tick(1, 0, 0);
    ntests++;
    if (nr_presses !== 8'd1) begin
      nfail++;
      $display("FAIL repress_after_reset: got %0d expected 1", nr_presses);
    end
    tick(0, 0, 0);
    tick(1, 0, 1);
    ntests++;
    if (nr_presses !== 8'd0) begin
      nfail++;
      $display("FAIL reset_priority: got %0d expected 0", nr_presses);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_subcycle();
    @(posedge clock0);
    #0.5 countu = 1'b1;
    #1   countu = 1'b0;
    tick(0, 0, 0);
    ntests++;
    if (nr_presses !== 8'd0) begin
      nfail++;
      $display("FAIL subcycle_pulse: got %0d expected 0", nr_presses);
    end
  endtask

  task automatic test_random();
    bit u;
    bit d;
    bit r;
    int bad;
    bad = 0;
    u = 0;
    d = 0;
    tick(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) u = ~u;
      if ($urandom_range(0, 2) == 0) d = ~d;
      r = ($urandom_range(0, 149) == 0);
      tick(u, d, r);
      ntests++;
      if (nr_presses !== 8'(m_cnt)) begin
        nfail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cycle %0d: got %0d expected %0d", i, nr_presses, m_cnt);
      end
    end
    tick(0, 0, 0);
  endtask

  initial begin
    ntests   = 0;
    nfail    = 0;
    m_cnt    = 0;
    m_prev_u = 1'b1;
    m_prev_d = 1'b1;
    reset    = 1'b1;
    countu   = 1'b0;
    countd   = 1'b0;
    test_reset();
    test_pulses();
    test_hold_down();
    test_hold_up();
    test_saturation();
    test_simultaneous();
    test_reset_mid_hold();
    test_subcycle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
